// File: rtl/rc4_seq_pkg.sv
// Shared types and constants for the RC4 key-search sequencer.
// Optional feature macro: RC4_SEQ_WATCHDOG_EN adds the WD_ERR state.
package rc4_seq_pkg;

    // Default last key of the search range (full 22-bit switch range)
    localparam logic [23:0] KEY_END_DEFAULT = 24'h3FFFFF;

    // One-hot-ish codes so each state lights a distinct LED
    typedef enum logic [7:0] {
        S_IDLE      = 8'h01,
        S_CLEAR     = 8'h02,
        S_LAUNCH    = 8'h04,
        S_RUN       = 8'h08,
        S_CHECK     = 8'h10,
        S_NEXT_KEY  = 8'h20,
        S_FOUND     = 8'h40,
`ifdef RC4_SEQ_WATCHDOG_EN
        S_EXHAUSTED = 8'h80,
        S_WD_ERR    = 8'hFF
`else
        S_EXHAUSTED = 8'h80
`endif
    } seq_state_t;

    // Width of the phase index register; never below one bit
    function automatic int phase_idx_w(input int n_phases);
        return (n_phases > 1) ? $clog2(n_phases) : 1;
    endfunction

endpackage

// File: rtl/rc4_crack_sequencer_if.sv
// Start/done handshake bundle between the sequencer and the per-phase FSMs.
interface rc4_crack_sequencer_if #(
    parameter int N_PHASES = 5
);
    logic                clear_all;
    logic [N_PHASES-1:0] phase_start;
    logic [N_PHASES-1:0] phase_go;
    logic [N_PHASES-1:0] phase_done;
    logic                key_valid;

    modport master (
        output clear_all, phase_start, phase_go,
        input  phase_done, key_valid
    );

    modport slave (
        input  clear_all, phase_start, phase_go,
        output phase_done, key_valid
    );
endinterface

// File: rtl/rc4_key_stepper.sv
// Loadable candidate-key counter with an end-of-range compare.
module rc4_key_stepper #(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 at_end
);

    assign at_end = (key == KEY_END);

    // Key register: load restarts the range, inc steps but never wraps past KEY_END
    always_ff @(posedge clk) begin
        if (rst) begin
            key <= KEY_START;
        end else if (load) begin
            key <= KEY_START;
        end else if (inc && !at_end) begin
            key <= key + 1'b1;
        end
    end

endmodule

// File: rtl/rc4_crack_sequencer.sv
// Top-level RC4 key-search sequencer: runs N_PHASES sub-FSMs per candidate key
// and stops on the first valid key or when the key range is exhausted.
// Optional feature macro: RC4_SEQ_WATCHDOG_EN (per-phase timeout, WD_ERR state).
module rc4_crack_sequencer
    import rc4_seq_pkg::*;
#(
    parameter int                   N_PHASES  = 5,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = KEY_WIDTH'(KEY_END_DEFAULT),
    parameter int                   TIMEOUT_W = 16
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    rc4_crack_sequencer_if.master  phase_bus,
    output logic [KEY_WIDTH-1:0]   current_key,
    output logic                   key_found,
    output logic                   search_failed,
    output logic                   wd_error,
    output logic                   busy,
    output logic [7:0]             current_state
);

    localparam int            PW     = phase_idx_w(N_PHASES);
    localparam logic [PW-1:0] LAST_P = PW'(N_PHASES - 1);

    seq_state_t    state;
    logic [PW-1:0] p;
    logic          valid_q;
    logic          waiting;
    logic          key_load;
    logic          key_inc;
    logic          key_at_end;

    function automatic logic [N_PHASES-1:0] phase_onehot(input logic [PW-1:0] idx);
        return N_PHASES'(1) << idx;
    endfunction

`ifdef RC4_SEQ_WATCHDOG_EN
    // Last counter value before the phase is declared hung; the increment
    // taken on this RUN cycle would land on all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);
    logic [TIMEOUT_W-1:0] wd_cnt;

    assign waiting = (state == S_IDLE) || (state == S_FOUND) ||
                     (state == S_EXHAUSTED) || (state == S_WD_ERR);
`else
    // TIMEOUT_W only sizes the watchdog counter, absent in this build
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_W[0];
    assign wd_error       = 1'b0;

    assign waiting = (state == S_IDLE) || (state == S_FOUND) ||
                     (state == S_EXHAUSTED);
`endif

    // abort outranks start and the key step, so the key is kept on abort
    assign key_load      = waiting && start && !abort;
    assign key_inc       = (state == S_NEXT_KEY) && !abort;
    assign current_state = state;

    rc4_key_stepper #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_START (KEY_START),
        .KEY_END   (KEY_END)
    ) u_key_stepper (
        .clk    (CLOCK_50),
        .rst    (reset),
        .load   (key_load),
        .inc    (key_inc),
        .key    (current_key),
        .at_end (key_at_end)
    );

    // Sequencer FSM with registered outputs; abort wins over every transition
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state                 <= S_IDLE;
            p                     <= '0;
            valid_q               <= 1'b0;
            phase_bus.clear_all   <= 1'b0;
            phase_bus.phase_start <= '0;
            phase_bus.phase_go    <= '0;
            key_found             <= 1'b0;
            search_failed         <= 1'b0;
            busy                  <= 1'b0;
`ifdef RC4_SEQ_WATCHDOG_EN
            wd_cnt                <= '0;
            wd_error              <= 1'b0;
`endif
        end else begin
            phase_bus.clear_all   <= 1'b0;
            phase_bus.phase_start <= '0;
            if (abort) begin
                state              <= S_IDLE;
                p                  <= '0;
                phase_bus.phase_go <= '0;
                key_found          <= 1'b0;
                search_failed      <= 1'b0;
                busy               <= 1'b0;
`ifdef RC4_SEQ_WATCHDOG_EN
                wd_error           <= 1'b0;
`endif
            end else if (waiting) begin
                if (start) begin
                    state               <= S_CLEAR;
                    p                   <= '0;
                    phase_bus.clear_all <= 1'b1;
                    busy                <= 1'b1;
                    key_found           <= 1'b0;
                    search_failed       <= 1'b0;
`ifdef RC4_SEQ_WATCHDOG_EN
                    wd_error            <= 1'b0;
`endif
                end
            end else begin
                case (state)
                    S_CLEAR: begin
                        state                 <= S_LAUNCH;
                        phase_bus.phase_start <= phase_onehot(p);
                        phase_bus.phase_go    <= phase_onehot(p);
                    end
                    S_LAUNCH: begin
                        state  <= S_RUN;
`ifdef RC4_SEQ_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                    S_RUN: begin
                        // Only the owned phase's done bit is meaningful
                        if (phase_bus.phase_done[p]) begin
                            if (p == LAST_P) begin
                                valid_q            <= phase_bus.key_valid;
                                phase_bus.phase_go <= '0;
                                state              <= S_CHECK;
                            end else begin
                                p                     <= p + 1'b1;
                                phase_bus.phase_start <= phase_onehot(p + 1'b1);
                                phase_bus.phase_go    <= phase_onehot(p + 1'b1);
                                state                 <= S_LAUNCH;
                            end
                        end
`ifdef RC4_SEQ_WATCHDOG_EN
                        else begin
                            wd_cnt <= wd_cnt + 1'b1;
                            if (wd_cnt == WD_LAST) begin
                                state              <= S_WD_ERR;
                                phase_bus.phase_go <= '0;
                                busy               <= 1'b0;
                                wd_error           <= 1'b1;
                            end
                        end
`endif
                    end
                    S_CHECK: begin
                        if (valid_q) begin
                            state     <= S_FOUND;
                            key_found <= 1'b1;
                            busy      <= 1'b0;
                        end else if (key_at_end) begin
                            state         <= S_EXHAUSTED;
                            search_failed <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            state <= S_NEXT_KEY;
                        end
                    end
                    S_NEXT_KEY: begin
                        state               <= S_CLEAR;
                        p                   <= '0;
                        phase_bus.clear_all <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_crack_sequencer.sv
// Self-checking bench for rc4_crack_sequencer: behavioural phase models,
// randomized latencies and valid keys, reference results from plain arithmetic.
module tb_rc4_crack_sequencer;

    localparam int NP = 3;
    localparam int KW = 8;
    localparam int TW = 4;
    localparam int KEND = 3;
    localparam logic [7:0] IDLE_CODE  = 8'h01;
    localparam logic [7:0] CLEAR_CODE = 8'h02;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [KW-1:0] current_key;
    logic          key_found;
    logic          search_failed;
    logic          wd_error;
    logic          busy;
    logic [7:0]    current_state;

    logic [NP-1:0] model_done = '0;
    logic [NP-1:0] force_done = '0;
    logic [KW-1:0] valid_key  = '1;
    logic          flush      = 1'b0;
    int            lat[NP];
    int            rem[NP];

    logic [KW-1:0] keys_tried[$];
    int            starts[$];
    int            busy_cnt = 0;
    int            mon_bad  = 0;
    int            checks   = 0;
    int            failures = 0;

    rc4_crack_sequencer_if #(.N_PHASES(NP)) bus ();

    assign bus.phase_done = model_done | force_done;
    assign bus.key_valid  = (current_key == valid_key);

    rc4_crack_sequencer #(
        .N_PHASES  (NP),
        .KEY_WIDTH (KW),
        .KEY_START (8'd0),
        .KEY_END   (8'd3),
        .TIMEOUT_W (TW)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst),
        .start         (start),
        .abort         (abort),
        .phase_bus     (bus),
        .current_key   (current_key),
        .key_found     (key_found),
        .search_failed (search_failed),
        .wd_error      (wd_error),
        .busy          (busy),
        .current_state (current_state)
    );

    always #5 clk = ~clk;

    // Phase sub-FSM models: done pulses on the lat-th cycle after the launch pulse
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            model_done[i] = 1'b0;
            if (flush) rem[i] = 0;
            else if (bus.phase_start[i]) rem[i] = lat[i];
            else if (rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 0) model_done[i] = 1'b1;
            end
        end
    end

    // Observer: records keys tried, launch order, busy cycles, one-hot violations
    always @(posedge clk) begin
        #1;
        if (bus.clear_all) keys_tried.push_back(current_key);
        for (int j = 0; j < NP; j++) if (bus.phase_start[j]) starts.push_back(j);
        if (busy) busy_cnt++;
        if ($countones(bus.phase_go) > 1 ||
            (bus.phase_start != '0 && bus.phase_start != bus.phase_go)) mon_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flush_models();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Runs one full search from a waiting state; vk > KEND means no key is valid
    task automatic run_search(input int vk, input bit stray, input string tag);
        int  nk, lsum, exp_key, nq;
        bit  found, seq_ok;
        keys_tried.delete();
        starts.delete();
        busy_cnt  = 0;
        valid_key = (vk <= KEND) ? KW'(vk) : '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_clear"}, 32'(bus.clear_all), 32'd1);
        chk({tag, "_key0"}, 32'(current_key), 32'd0);
        chk({tag, "_state_clear"}, 32'(current_state), 32'(CLEAR_CODE));
        if (stray) begin
            repeat (2) @(negedge clk);
            force_done[NP-1] = 1'b1;
            @(negedge clk);
            force_done[NP-1] = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            if (key_found || search_failed) break;
            @(negedge clk);
        end
        chk({tag, "_finished"}, 32'(key_found | search_failed), 32'd1);

        found   = (vk <= KEND);
        nk      = found ? vk + 1 : KEND + 1;
        exp_key = found ? vk : KEND;
        lsum    = (force_done[0] ? 1 : lat[0]) + lat[1] + lat[2];
        seq_ok  = 1'b1;
        for (int i = 0; i < keys_tried.size(); i++) if (keys_tried[i] != KW'(i)) seq_ok = 1'b0;
        for (int i = 0; i < starts.size(); i++) if (starts[i] != i % NP) seq_ok = 1'b0;

        chk({tag, "_found"}, 32'(key_found), 32'(found));
        chk({tag, "_failed"}, 32'(search_failed), 32'(!found));
        chk({tag, "_key"}, 32'(current_key), 32'(exp_key));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_nkeys"}, 32'(keys_tried.size()), 32'(nk));
        chk({tag, "_nstarts"}, 32'(starts.size()), 32'(nk * NP));
        chk({tag, "_order"}, 32'(seq_ok), 32'd1);
        chk({tag, "_cycles"}, 32'(busy_cnt), 32'(nk * (2 + NP + lsum) + nk - 1));
        nq = keys_tried.size();
        repeat (4) @(negedge clk);
        chk({tag, "_hold"}, 32'({key_found, search_failed, current_key, keys_tried.size() == nq}),
            32'({found, !found, KW'(exp_key), 1'b1}));
    endtask

    initial begin
        int vk;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lat   = '{4, 7, 2};
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(current_state), 32'(IDLE_CODE));
        chk("rst_outs", 32'({bus.clear_all, bus.phase_start, bus.phase_go, key_found,
                            search_failed, wd_error, busy}), 32'd0);
        chk("rst_key", 32'(current_key), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'(current_state), 32'(IDLE_CODE));

        // Directed: valid only at key 2, then never valid
        run_search(2, 1'b0, "found2");
        run_search(99, 1'b0, "exhaust");

        // Randomized latencies and valid keys, restarting from FOUND/EXHAUSTED
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NP; i++) lat[i] = $urandom_range(1, 8);
            vk = $urandom_range(0, 5);
            run_search(vk, 1'b0, "rand");
        end

        // Phase 0 done held high: completes on its first RUN cycle every key
        lat = '{5, 3, 2};
        force_done[0] = 1'b1;
        run_search(1, 1'b0, "hold0");
        force_done[0] = 1'b0;

        // Stray done of the last phase while phase 0 is running
        lat = '{6, 2, 3};
        run_search(3, 1'b1, "stray");

        // Abort in RUN of phase 1, key 1
        lat = '{3, 20, 3};
        valid_key = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (current_key == KW'(1) && bus.phase_go == 3'b010) break;
            @(negedge clk);
        end
        chk("abort_reach", 32'({current_key, bus.phase_go}), 32'({8'd1, 3'b010}));
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", 32'(current_state), 32'(IDLE_CODE));
        chk("abort_outs", 32'({bus.phase_go, bus.phase_start, busy}), 32'd0);
        chk("abort_key", 32'(current_key), 32'd1);
        flush_models();
        repeat (3) @(negedge clk);
        chk("abort_stay", 32'(current_state), 32'(IDLE_CODE));
        lat = '{2, 3, 1};
        run_search(99, 1'b0, "resume");

        // Reset and abort together mid-search
        lat = '{3, 4, 5};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (current_key == KW'(2)) break;
            @(negedge clk);
        end
        chk("ra_reach", 32'(current_key), 32'd2);
        rst   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("ra_state", 32'(current_state), 32'(IDLE_CODE));
        chk("ra_outs", 32'({bus.clear_all, bus.phase_start, bus.phase_go, key_found,
                           search_failed, wd_error, busy}), 32'd0);
        chk("ra_key", 32'(current_key), 32'd0);
        rst   = 1'b0;
        abort = 1'b0;
        flush_models();

`ifdef RC4_SEQ_WATCHDOG_EN
        // Phase 1 hangs: watchdog trips after 15 RUN cycles
        lat = '{2, 100, 2};
        valid_key = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.phase_start == 3'b010) break;
            @(negedge clk);
        end
        chk("wd_launch", 32'(bus.phase_start), 32'd2);
        repeat (15) @(negedge clk);
        chk("wd_not_yet", 32'(wd_error), 32'd0);
        @(negedge clk);
        chk("wd_trip", 32'(wd_error), 32'd1);
        chk("wd_go_off", 32'({bus.phase_go, busy}), 32'd0);
        chk("wd_key", 32'(current_key), 32'd0);
        flush_models();
        lat = '{2, 2, 2};
        run_search(1, 1'b0, "wd_restart");
        chk("wd_cleared", 32'(wd_error), 32'd0);
`else
        chk("wd_tied", 32'(wd_error), 32'd0);
`endif

        chk("onehot_mon", 32'(mon_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
